// File: rtl/md_unit.sv
// Multi-cycle MIPS multiply/divide unit holding HI/LO; MULT/DIV results commit after a fixed busy window.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are compiled in when MDU_MADD_EN is defined.
module md_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  e_op,
    input  logic        e_hold,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_md,
    output logic [31:0] md_out,
    output logic        busy,
    output logic        start,
    output logic        md_stall
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   pend_q, pend_d;
    logic          pwr_q, pwr_d;

    logic        is_mul, is_div, is_mac, mul_sgn, div_sgn, mt_acc, div_zero;
    logic [63:0] op_a, op_b, prod, result;
    logic [31:0] a_mag, b_mag, divisor, q_u, r_u, quo, rem;

    always_comb begin
        is_mul  = (e_op == OP_MULT) || (e_op == OP_MULTU);
        is_div  = (e_op == OP_DIV)  || (e_op == OP_DIVU);
        mul_sgn = (e_op == OP_MULT);
        is_mac  = 1'b0;
`ifdef MDU_MADD_EN
        is_mac  = (e_op == OP_MADD) || (e_op == OP_MADDU) ||
                  (e_op == OP_MSUB) || (e_op == OP_MSUBU);
        if (e_op == OP_MADD || e_op == OP_MSUB)
            mul_sgn = 1'b1;
`endif
        div_sgn = (e_op == OP_DIV);
    end

    assign start    = (is_mul || is_div || is_mac) && !busy_q && !e_hold && !reset;
    assign mt_acc   = ((e_op == OP_MTHI) || (e_op == OP_MTLO)) && !busy_q && !e_hold && !reset;
    assign busy     = busy_q;
    assign md_stall = d_md && (start || busy_q);

    // One 64x64 multiplier serves signed and unsigned: sign-extend only for signed ops.
    assign op_a = {{32{mul_sgn & a[31]}}, a};
    assign op_b = {{32{mul_sgn & b[31]}}, b};
    assign prod = op_a * op_b;

    // Signed divide runs on magnitudes so 0x80000000 / -1 cannot overflow the divider.
    assign a_mag    = (div_sgn && a[31]) ? -a : a;
    assign b_mag    = (div_sgn && b[31]) ? -b : b;
    assign div_zero = (b == 32'd0);
    assign divisor  = div_zero ? 32'd1 : b_mag;
    assign q_u      = a_mag / divisor;
    assign r_u      = a_mag % divisor;
    assign quo      = (div_sgn && (a[31] ^ b[31])) ? -q_u : q_u;
    assign rem      = (div_sgn && a[31]) ? -r_u : r_u;

    always_comb begin
        result = prod;
        if (is_div)
            result = {rem, quo};
`ifdef MDU_MADD_EN
        if (e_op == OP_MADD || e_op == OP_MADDU)
            result = {hi_q, lo_q} + prod;
        else if (e_op == OP_MSUB || e_op == OP_MSUBU)
            result = {hi_q, lo_q} - prod;
`endif
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        pend_d = pend_q;
        pwr_d  = pwr_q;
        if (start) begin
            busy_d = 1'b1;
            pend_d = result;
            pwr_d  = !(is_div && div_zero);
            cnt_d  = is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
        end else if (busy_q) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                if (pwr_q)
                    {hi_d, lo_d} = pend_q;
            end
        end else if (mt_acc) begin
            if (e_op == OP_MTHI)
                hi_d = a;
            else
                lo_d = a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
            pend_q <= '0;
            pwr_q  <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            pwr_q  <= pwr_d;
        end
    end

    always_comb begin
        md_out = '0;
        if (e_op == OP_MFHI)
            md_out = hi_q;
        else if (e_op == OP_MFLO)
            md_out = lo_q;
    end
endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: reset, mult/div, moves, stall, abort, optional MADD.
module tb_md_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  e_op;
    logic        e_hold;
    logic [31:0] a, b;
    logic        d_md;
    logic [31:0] md_out;
    logic        busy, start, md_stall;

    int tests = 0;
    int fails = 0;

    md_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .e_op(e_op), .e_hold(e_hold), .a(a), .b(b),
        .d_md(d_md), .md_out(md_out), .busy(busy), .start(start), .md_stall(md_stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single accepted cycle, then return to idle.
    task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        e_op = op; a = av; b = bv;
        tick();
        e_op = 4'd0; a = '0; b = '0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic read_hilo(output logic [31:0] hv, output logic [31:0] lv);
        logic [3:0] save;
        save = e_op;
        e_op = 4'd7; #1; hv = md_out;
        e_op = 4'd8; #1; lv = md_out;
        e_op = save; #1;
    endtask

    task automatic test_reset();
        logic [31:0] hv, lv;
        reset = 1'b1; e_op = 4'd1; e_hold = 1'b0; a = 32'd3; b = 32'd3; d_md = 1'b0;
        #1;
        tests++; if (start !== 1'b0) begin fails++; $display("FAIL reset_start got %b want 0", start); end
        tick(); tick();
        reset = 1'b0; e_op = 4'd0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        read_hilo(hv, lv);
        tests++; if (hv !== 32'd0 || lv !== 32'd0) begin fails++; $display("FAIL reset_hilo got %h/%h want 0/0", hv, lv); end
        e_op = 4'd0; #1;
        tests++; if (md_out !== 32'd0) begin fails++; $display("FAIL md_out_none got %h want 0", md_out); end
    endtask

    task automatic test_mult();
        int n;
        logic [31:0] hv, lv;
        e_op = 4'd1; a = 32'hFFFFFFFE; b = 32'd3; #1;
        tests++; if (start !== 1'b1) begin fails++; $display("FAIL mult_start got %b want 1", start); end
        tick();
        #1;
        tests++; if (start !== 1'b0) begin fails++; $display("FAIL mult_start_once got %b want 0", start); end
        e_op = 4'd0; a = '0; b = '0;
        wait_idle(n);
        tests++; if (n !== 5) begin fails++; $display("FAIL mult_busy_cycles got %0d want 5", n); end
        read_hilo(hv, lv);
        tests++; if (hv !== 32'hFFFFFFFF || lv !== 32'hFFFFFFFA) begin fails++; $display("FAIL mult_hilo got %h/%h want ffffffff/fffffffa", hv, lv); end
        issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle(n);
        read_hilo(hv, lv);
        tests++; if (hv !== 32'hFFFFFFFE || lv !== 32'h00000001) begin fails++; $display("FAIL multu_hilo got %h/%h want fffffffe/00000001", hv, lv); end
    endtask

    task automatic test_div();
        int n;
        logic [31:0] hv, lv;
        issue(4'd4, 32'd100, 32'd7);
        wait_idle(n);
        tests++; if (n !== 10) begin fails++; $display("FAIL divu_busy_cycles got %0d want 10", n); end
        read_hilo(hv, lv);
        tests++; if (hv !== 32'd2 || lv !== 32'd14) begin fails++; $display("FAIL divu_hilo got %h/%h want 2/14", hv, lv); end
        issue(4'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        read_hilo(hv, lv);
        tests++; if (hv !== 32'hFFFFFFFF || lv !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_neg_hilo got %h/%h want ffffffff/fffffffd", hv, lv); end
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        read_hilo(hv, lv);
        tests++; if (hv !== 32'd0 || lv !== 32'h80000000) begin fails++; $display("FAIL div_ovf_hilo got %h/%h want 0/80000000", hv, lv); end
        issue(4'd4, 32'd55, 32'd0);
        wait_idle(n);
        tests++; if (n !== 10) begin fails++; $display("FAIL div0_busy_cycles got %0d want 10", n); end
        read_hilo(hv, lv);
        tests++; if (hv !== 32'd0 || lv !== 32'h80000000) begin fails++; $display("FAIL div0_hilo got %h/%h want 0/80000000", hv, lv); end
    endtask

    task automatic test_move();
        int n;
        logic [31:0] hv, lv;
        issue(4'd6, 32'h12345678, 32'd0);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mtlo_busy got %b want 0", busy); end
        read_hilo(hv, lv);
        tests++; if (lv !== 32'h12345678) begin fails++; $display("FAIL mtlo_lo got %h want 12345678", lv); end
        issue(4'd5, 32'h11111111, 32'd0);
        issue(4'd1, 32'd2, 32'd3);
        issue(4'd5, 32'hDEADBEEF, 32'd0);
        read_hilo(hv, lv);
        tests++; if (hv !== 32'h11111111) begin fails++; $display("FAIL mthi_busy_hi got %h want 11111111", hv); end
        wait_idle(n);
        read_hilo(hv, lv);
        tests++; if (hv !== 32'd0 || lv !== 32'd6) begin fails++; $display("FAIL mult_after_mthi got %h/%h want 0/6", hv, lv); end
    endtask

    task automatic test_stall();
        int bad;
        d_md = 1'b1; e_op = 4'd2; a = 32'd5; b = 32'd5; #1;
        tests++; if (md_stall !== 1'b1) begin fails++; $display("FAIL stall_start got %b want 1", md_stall); end
        tick();
        e_op = 4'd0; #1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (md_stall !== 1'b1 || busy !== 1'b1) bad++;
            tick();
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL stall_busy got %0d bad cycles want 0", bad); end
        tests++; if (md_stall !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL stall_release got stall=%b busy=%b want 0/0", md_stall, busy); end
        d_md = 1'b0;
        e_hold = 1'b1; e_op = 4'd1; a = 32'd9; b = 32'd9; #1;
        tests++; if (start !== 1'b0) begin fails++; $display("FAIL hold_start got %b want 0", start); end
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL hold_busy got %b want 0", busy); end
        e_hold = 1'b0; e_op = 4'd0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] hv, lv;
        issue(4'd4, 32'd100, 32'd7);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
        read_hilo(hv, lv);
        tests++; if (hv !== 32'd0 || lv !== 32'd0) begin fails++; $display("FAIL abort_hilo got %h/%h want 0/0", hv, lv); end
        for (int i = 0; i < 12; i++) tick();
        read_hilo(hv, lv);
        tests++; if (hv !== 32'd0 || lv !== 32'd0 || busy !== 1'b0) begin fails++; $display("FAIL abort_late got %h/%h busy=%b want 0/0/0", hv, lv, busy); end
    endtask

    task automatic test_madd();
        int n;
        logic [31:0] hv, lv;
        issue(4'd5, 32'd0, 32'd0);
        issue(4'd6, 32'hFFFFFFFF, 32'd0);
        e_op = 4'd10; a = 32'd1; b = 32'd1; #1;
`ifdef MDU_MADD_EN
        tests++; if (start !== 1'b1) begin fails++; $display("FAIL maddu_start got %b want 1", start); end
        tick();
        e_op = 4'd0; a = '0; b = '0;
        wait_idle(n);
        tests++; if (n !== 5) begin fails++; $display("FAIL maddu_busy_cycles got %0d want 5", n); end
        read_hilo(hv, lv);
        tests++; if (hv !== 32'd1 || lv !== 32'd0) begin fails++; $display("FAIL maddu_hilo got %h/%h want 1/0", hv, lv); end
`else
        tests++; if (start !== 1'b0) begin fails++; $display("FAIL maddu_off_start got %b want 0", start); end
        tick();
        e_op = 4'd0; a = '0; b = '0;
        wait_idle(n);
        tests++; if (n !== 0) begin fails++; $display("FAIL maddu_off_busy got %0d want 0", n); end
        read_hilo(hv, lv);
        tests++; if (hv !== 32'd0 || lv !== 32'hFFFFFFFF) begin fails++; $display("FAIL maddu_off_hilo got %h/%h want 0/ffffffff", hv, lv); end
`endif
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_move();
        test_stall();
        test_reset_mid();
        test_madd();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
